// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin codes and values,
// and selection error codes.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDispense = 2'd1,
    StChange   = 2'd2
  } state_e;

  localparam logic [1:0] CoinNone    = 2'b00;
  localparam logic [1:0] CoinNickel  = 2'b01;
  localparam logic [1:0] CoinDime    = 2'b10;
  localparam logic [1:0] CoinQuarter = 2'b11;

  localparam logic [4:0] ValNickel  = 5'd5;
  localparam logic [4:0] ValDime    = 5'd10;
  localparam logic [4:0] ValQuarter = 5'd25;

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrSlot  = 2'b01;
  localparam logic [1:0] ErrFunds = 2'b10;

  function automatic logic [4:0] coin_value(logic [1:0] coin);
    case (coin)
      CoinNickel:  return ValNickel;
      CoinDime:    return ValDime;
      CoinQuarter: return ValQuarter;
      default:     return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Change payout: greedy coin selection and the coin valid/ready handshake to the hopper.
// Reports the decremented credit and when payout is finished.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic [PRICE_W-1:0] credit,
  input  logic               coin_out_ready,
  output logic               coin_out_valid,
  output logic [1:0]         coin_out_type,
  output logic [PRICE_W-1:0] credit_next,
  output logic               done
);

  logic               valid_q;
  logic [1:0]         type_q;
  logic               paid;
  logic               slot_free;
  logic [PRICE_W-1:0] rem;
  logic [1:0]         next_type;

  always_comb begin
    paid      = valid_q & coin_out_ready;
    slot_free = ~valid_q | paid;
    rem       = paid ? credit - PRICE_W'(coin_value(type_q)) : credit;
    if (rem >= PRICE_W'(ValQuarter))   next_type = CoinQuarter;
    else if (rem >= PRICE_W'(ValDime)) next_type = CoinDime;
    else if (rem >= PRICE_W'(ValNickel)) next_type = CoinNickel;
    else                               next_type = CoinNone;
    // Finished once no coin is pending and less than a nickel remains; residual is dropped.
    done        = active & slot_free & (next_type == CoinNone);
    credit_next = done ? '0 : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      type_q  <= CoinNone;
    end else if (!active) begin
      valid_q <= 1'b0;
      type_q  <= CoinNone;
    end else if (slot_free) begin
      valid_q <= (next_type != CoinNone);
      type_q  <= next_type;
    end
  end

  assign coin_out_valid = valid_q;
  assign coin_out_type  = type_q;

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, slot selection, dispense handshake and change payout.
// Optional idle auto-cancel is built only when VEND_TIMEOUT_EN is defined.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 7,
  parameter int unsigned PRICE_W        = 9,
  parameter int unsigned MAX_CREDIT     = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         nickel,
  input  logic                         dime,
  input  logic                         quarter,
  input  logic                         sel_valid,
  input  logic [2:0]                   sel_index,
  input  logic                         cancel,
  input  logic [NUM_SLOTS*PRICE_W-1:0] price_table,
  output logic                         dispense_req,
  output logic [2:0]                   dispense_index,
  input  logic                         dispense_ack,
  output logic                         coin_out_valid,
  output logic [1:0]                   coin_out_type,
  input  logic                         coin_out_ready,
  output logic [PRICE_W-1:0]           credit,
  output logic                         coin_reject,
  output logic                         vend_done,
  output logic                         vend_error,
  output logic [1:0]                   err_code
);

  localparam int unsigned SumW = PRICE_W + 1;

  if (MAX_CREDIT >= (1 << PRICE_W)) begin : g_bad_max_credit
    $error("MAX_CREDIT does not fit in PRICE_W bits");
  end
  if (NUM_SLOTS > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("NUM_SLOTS must fit a 3-bit index and TIMEOUT_CYCLES must be nonzero");
  end

  state_e             state_q, state_d;
  logic [PRICE_W-1:0] credit_q, credit_d;
  logic               vend_flag_q, vend_flag_d;
  logic               dispense_req_q, dispense_req_d;
  logic [2:0]         dispense_index_q, dispense_index_d;
  logic               coin_reject_q, coin_reject_d;
  logic               vend_done_q, vend_done_d;
  logic               vend_error_q, vend_error_d;
  logic [1:0]         err_code_q, err_code_d;

  logic               coin_any, cancel_eff, timeout_fire, sel_in_range;
  logic [SumW-1:0]    coin_sum, base, total;
  logic [PRICE_W-1:0] sel_price, change_credit;
  logic               change_done;

  assign coin_any = nickel | dime | quarter;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] idle_cnt_q;

  assign timeout_fire = (state_q == StIdle) && (credit_q != '0) &&
                        (idle_cnt_q == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else if (state_q != StIdle || credit_q == '0 || coin_any || sel_valid || cancel ||
                 timeout_fire) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  assign cancel_eff = cancel | timeout_fire;

  always_comb begin
    sel_in_range = (32'(sel_index) < NUM_SLOTS);
    sel_price    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (32'(sel_index) == i) sel_price = price_table[i*PRICE_W +: PRICE_W];
    end
    coin_sum = (nickel  ? SumW'(ValNickel)  : '0) +
               (dime    ? SumW'(ValDime)    : '0) +
               (quarter ? SumW'(ValQuarter) : '0);
  end

  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    vend_flag_d      = vend_flag_q;
    dispense_req_d   = dispense_req_q;
    dispense_index_d = dispense_index_q;
    coin_reject_d    = 1'b0;
    vend_done_d      = 1'b0;
    vend_error_d     = 1'b0;
    err_code_d       = ErrNone;
    base             = {1'b0, credit_q};
    total            = '0;

    unique case (state_q)
      StIdle: begin
        if (cancel_eff) begin
          if (credit_q != '0) begin
            state_d     = StChange;
            vend_flag_d = 1'b0;
          end
        end else if (sel_valid) begin
          if (!sel_in_range || sel_price == '0) begin
            vend_error_d = 1'b1;
            err_code_d   = ErrSlot;
          end else if (credit_q < sel_price) begin
            vend_error_d = 1'b1;
            err_code_d   = ErrFunds;
          end else begin
            base             = {1'b0, credit_q} - {1'b0, sel_price};
            state_d          = StDispense;
            dispense_req_d   = 1'b1;
            dispense_index_d = sel_index;
          end
        end
        // Same-cycle coins are judged against the post-purchase credit as one increment.
        total = base + coin_sum;
        if (coin_any && total > SumW'(MAX_CREDIT)) begin
          coin_reject_d = 1'b1;
          credit_d      = base[PRICE_W-1:0];
        end else begin
          credit_d = total[PRICE_W-1:0];
        end
      end
      StDispense: begin
        coin_reject_d = coin_any;
        if (dispense_ack) begin
          dispense_req_d   = 1'b0;
          dispense_index_d = '0;
          state_d          = StChange;
          vend_flag_d      = 1'b1;
        end
      end
      StChange: begin
        coin_reject_d = coin_any;
        credit_d      = change_credit;
        if (change_done) begin
          state_d     = StIdle;
          vend_done_d = vend_flag_q;
          vend_flag_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      credit_q         <= '0;
      vend_flag_q      <= 1'b0;
      dispense_req_q   <= 1'b0;
      dispense_index_q <= '0;
      coin_reject_q    <= 1'b0;
      vend_done_q      <= 1'b0;
      vend_error_q     <= 1'b0;
      err_code_q       <= ErrNone;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      vend_flag_q      <= vend_flag_d;
      dispense_req_q   <= dispense_req_d;
      dispense_index_q <= dispense_index_d;
      coin_reject_q    <= coin_reject_d;
      vend_done_q      <= vend_done_d;
      vend_error_q     <= vend_error_d;
      err_code_q       <= err_code_d;
    end
  end

  vend_change_unit #(
    .PRICE_W(PRICE_W)
  ) u_change (
    .clk            (clk),
    .rst            (rst),
    .active         (state_q == StChange),
    .credit         (credit_q),
    .coin_out_ready (coin_out_ready),
    .coin_out_valid (coin_out_valid),
    .coin_out_type  (coin_out_type),
    .credit_next    (change_credit),
    .done           (change_done)
  );

  assign credit         = credit_q;
  assign dispense_req   = dispense_req_q;
  assign dispense_index = dispense_index_q;
  assign coin_reject    = coin_reject_q;
  assign vend_done      = vend_done_q;
  assign vend_error     = vend_error_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: cycle model with a precomputed change list,
// compared every cycle, plus hand-computed literal checks of key scenarios.
module tb_vend_controller;

  localparam int NS = 7;
  localparam int PW = 9;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          nickel, dime, quarter, sel_valid, cancel;
  logic [2:0]    sel_index;
  logic [NS*PW-1:0] price_table;
  logic          dispense_req;
  logic [2:0]    dispense_index;
  logic          dispense_ack;
  logic          coin_out_valid;
  logic [1:0]    coin_out_type;
  logic          coin_out_ready;
  logic [PW-1:0] credit;
  logic          coin_reject, vend_done, vend_error;
  logic [1:0]    err_code;

  vend_controller #(
    .NUM_SLOTS      (NS),
    .PRICE_W        (PW),
    .MAX_CREDIT     (500),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .nickel         (nickel),
    .dime           (dime),
    .quarter        (quarter),
    .sel_valid      (sel_valid),
    .sel_index      (sel_index),
    .cancel         (cancel),
    .price_table    (price_table),
    .dispense_req   (dispense_req),
    .dispense_index (dispense_index),
    .dispense_ack   (dispense_ack),
    .coin_out_valid (coin_out_valid),
    .coin_out_type  (coin_out_type),
    .coin_out_ready (coin_out_ready),
    .credit         (credit),
    .coin_reject    (coin_reject),
    .vend_done      (vend_done),
    .vend_error     (vend_error),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int prices[NS] = '{50, 100, 20, 35, 75, 0, 63};
  logic [1:0] paid_log[$];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: money as plain integers; change is a precomputed greedy list of coins.
  int   m_credit, m_mode, m_vend, m_idle;
  int   m_q[$];
  int   e_idx, e_type, e_code;
  bit   e_req, e_valid, e_reject, e_done, e_error;

  function automatic int val_of(int t);
    return (t == 3) ? 25 : (t == 2) ? 10 : (t == 1) ? 5 : 0;
  endfunction

  task automatic build_change();
    int amt = m_credit;
    m_q.delete();
    while (amt >= 25) begin m_q.push_back(3); amt -= 25; end
    while (amt >= 10) begin m_q.push_back(2); amt -= 10; end
    while (amt >= 5)  begin m_q.push_back(1); amt -= 5;  end
  endtask

  task automatic model_reset();
    m_credit = 0; m_mode = 0; m_vend = 0; m_idle = 0; m_q.delete();
    e_req = 0; e_idx = 0; e_valid = 0; e_type = 0;
    e_reject = 0; e_done = 0; e_error = 0; e_code = 0;
  endtask

  task automatic model_step();
    int  sum = (nickel ? 5 : 0) + (dime ? 10 : 0) + (quarter ? 25 : 0);
    bit  any = (sum != 0);
    bit  fire = 0;
    bit  paid;
    int  base, price, nxt;
    e_reject = 0; e_done = 0; e_error = 0; e_code = 0;
`ifdef VEND_TIMEOUT_EN
    fire = (m_mode == 0 && m_credit > 0 && m_idle == TO);
    if (m_mode != 0 || m_credit == 0 || any || sel_valid || cancel || fire) m_idle = 0;
    else m_idle++;
`endif
    case (m_mode)
      0: begin
        base = m_credit;
        nxt  = 0;
        if (cancel || fire) begin
          if (m_credit > 0) nxt = 2;
        end else if (sel_valid) begin
          price = (int'(sel_index) < NS) ? prices[sel_index] : 0;
          if (price == 0) begin
            e_error = 1; e_code = 1;
          end else if (m_credit < price) begin
            e_error = 1; e_code = 2;
          end else begin
            base -= price; nxt = 1; e_req = 1; e_idx = int'(sel_index);
          end
        end
        if (any) begin
          if (base + sum > 500) e_reject = 1;
          else base += sum;
        end
        m_credit = base;
        m_mode   = nxt;
        if (nxt == 2) begin m_vend = 0; build_change(); end
      end
      1: begin
        e_reject = any;
        if (dispense_ack) begin
          e_req = 0; e_idx = 0; m_mode = 2; m_vend = 1; build_change();
        end
      end
      default: begin
        e_reject = any;
        paid = e_valid && coin_out_ready;
        if (paid) m_credit -= val_of(m_q.pop_front());
        if (!e_valid || paid) begin
          if (m_q.size() > 0) begin
            e_valid = 1; e_type = m_q[0];
          end else begin
            e_valid = 0; e_type = 0; e_done = (m_vend != 0);
            m_vend = 0; m_credit = 0; m_mode = 0;
          end
        end
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(posedge clk) begin
    if (!rst && coin_out_valid && coin_out_ready) paid_log.push_back(coin_out_type);
    if (!rst && vend_done) n_done++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("credit", int'(credit), m_credit);
      check("dispense_req", int'(dispense_req), int'(e_req));
      check("dispense_index", int'(dispense_index), e_idx);
      check("coin_out_valid", int'(coin_out_valid), int'(e_valid));
      check("coin_out_type", int'(coin_out_type), e_type);
      check("coin_reject", int'(coin_reject), int'(e_reject));
      check("vend_done", int'(vend_done), int'(e_done));
      check("vend_error", int'(vend_error), int'(e_error));
      check("err_code", int'(err_code), e_code);
    end
  end

  task automatic pulse(bit n, bit d, bit q, bit sv, logic [2:0] idx, bit c);
    nickel = n; dime = d; quarter = q; sel_valid = sv; sel_index = idx; cancel = c;
    @(posedge clk); #1;
    nickel = 0; dime = 0; quarter = 0; sel_valid = 0; sel_index = 0; cancel = 0;
  endtask

  task automatic wait_cycles(int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1; nickel = 0; dime = 0; quarter = 0; sel_valid = 0; sel_index = 0; cancel = 0;
    dispense_ack = 0; coin_out_ready = 0;
    for (int i = 0; i < NS; i++) price_table[i*PW +: PW] = PW'(prices[i]);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset credit", int'(credit), 0);
    check("reset outputs", int'({dispense_req, coin_out_valid, coin_out_type, coin_reject,
                                 vend_done, vend_error, err_code}), 0);
    rst = 0;

    // Four nickels, buy slot 2 at 20: no change owed.
    repeat (4) pulse(1, 0, 0, 0, 0, 0);
    check("four nickels credit", int'(credit), 20);
    pulse(0, 0, 0, 1, 3'd2, 0);
    check("sel2 req", int'(dispense_req), 1);
    check("sel2 index", int'(dispense_index), 2);
    check("sel2 credit", int'(credit), 0);
    wait_cycles(2);
    check("req held", int'(dispense_req), 1);
    dispense_ack = 1; wait_cycles(1); dispense_ack = 0;
    check("req dropped", int'(dispense_req), 0);
    wait_cycles(1);
    check("zero change done", int'(vend_done), 1);
    check("zero change no coin", int'(coin_out_valid), 0);

    // 60 cents, buy slot 0 at 50: one dime with hopper stalling.
    pulse(0, 0, 1, 0, 0, 0); pulse(0, 0, 1, 0, 0, 0); pulse(0, 1, 0, 0, 0, 0);
    check("60 credit", int'(credit), 60);
    pulse(0, 0, 0, 1, 3'd0, 0);
    check("sel0 credit", int'(credit), 10);
    dispense_ack = 1; wait_cycles(1); dispense_ack = 0;
    wait_cycles(1);
    check("dime offered", int'(coin_out_type), 2);
    wait_cycles(3);
    check("dime held valid", int'(coin_out_valid), 1);
    check("dime held type", int'(coin_out_type), 2);
    coin_out_ready = 1; wait_cycles(1); coin_out_ready = 0;
    check("dime done", int'(vend_done), 1);
    check("dime credit", int'(credit), 0);

    // Selection errors; quarter + nickel in one cycle sums to 30.
    pulse(1, 0, 1, 0, 0, 0);
    check("combined coins", int'(credit), 30);
    pulse(0, 0, 0, 1, 3'd5, 0);
    check("out of stock code", int'(err_code), 1);
    pulse(0, 0, 0, 1, 3'd1, 0);
    check("funds code", int'(err_code), 2);
    check("funds credit kept", int'(credit), 30);
    pulse(0, 0, 0, 1, 3'd7, 0);
    check("bad slot code", int'(err_code), 1);

    // Cancel at 40: quarter, dime, nickel back to back, no vend_done.
    pulse(0, 1, 0, 0, 0, 0);
    coin_out_ready = 1;
    paid_log.delete();
    n_done = 0;
    pulse(0, 0, 0, 0, 0, 1);
    wait_cycles(5);
    coin_out_ready = 0;
    check("refund count", paid_log.size(), 3);
    if (paid_log.size() == 3) begin
      check("refund 1", int'(paid_log[0]), 3);
      check("refund 2", int'(paid_log[1]), 2);
      check("refund 3", int'(paid_log[2]), 1);
    end
    check("refund no done", n_done, 0);

    // Credit ceiling at 500, coins refused during dispense.
    repeat (14) pulse(0, 1, 1, 0, 0, 0);
    check("490 credit", int'(credit), 490);
    pulse(0, 0, 1, 0, 0, 0);
    check("over max reject", int'(coin_reject), 1);
    check("over max credit", int'(credit), 490);
    pulse(0, 1, 0, 0, 0, 0);
    check("exact max accepted", int'(credit), 500);
    pulse(1, 0, 0, 0, 0, 0);
    check("past max reject", int'(coin_reject), 1);
    pulse(0, 0, 0, 1, 3'd4, 0);
    check("sel4 credit", int'(credit), 425);
    pulse(0, 0, 1, 0, 0, 0);
    check("dispense coin reject", int'(coin_reject), 1);
    dispense_ack = 1; wait_cycles(1); dispense_ack = 0;
    coin_out_ready = 1; paid_log.delete(); n_done = 0;
    wait_cycles(22);
    coin_out_ready = 0;
    check("17 quarters", paid_log.size(), 17);
    check("big change done", n_done, 1);

    // Residual: 65 - 63 leaves 2 cents, cleared without a coin.
    pulse(1, 1, 1, 0, 0, 0); pulse(0, 0, 1, 0, 0, 0);
    pulse(0, 0, 0, 1, 3'd6, 0);
    check("residual credit", int'(credit), 2);
    dispense_ack = 1; wait_cycles(1); dispense_ack = 0;
    wait_cycles(1);
    check("residual cleared", int'(credit), 0);
    check("residual done", int'(vend_done), 1);

    // Reset during change payout.
    pulse(0, 1, 1, 0, 0, 0);
    pulse(0, 0, 0, 0, 0, 1);
    wait_cycles(2);
    check("pre-reset valid", int'(coin_out_valid), 1);
    rst = 1;
    #1;
    check("async reset valid", int'(coin_out_valid), 0);
    check("async reset type", int'(coin_out_type), 0);
    check("async reset credit", int'(credit), 0);
    wait_cycles(2);
    rst = 0;
    wait_cycles(2);

`ifdef VEND_TIMEOUT_EN
    pulse(1, 1, 0, 0, 0, 0);
    coin_out_ready = 1; paid_log.delete();
    wait_cycles(14);
    coin_out_ready = 0;
    check("timeout refund count", paid_log.size(), 2);
    if (paid_log.size() == 2) begin
      check("timeout dime", int'(paid_log[0]), 2);
      check("timeout nickel", int'(paid_log[1]), 1);
    end
    check("timeout credit", int'(credit), 0);
`endif

    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing controller for the vending datapath.
- Accumulates coin credit and validates a slot selection against the price table.
- Drives a dispense handshake to the product mechanism, then pays out change coin by coin over a valid/ready handshake to the coin hopper.
- All money values are in cents, 9-bit unsigned, matching the 9-bit change path.

Parameters:
- NUM_SLOTS, 7, number of product slots; indices 0..NUM_SLOTS-1 are valid.
- PRICE_W, 9, width of each price entry, credit and change in cents.
- MAX_CREDIT, 500, credit ceiling in cents; must be below 2^PRICE_W.
- TIMEOUT_CYCLES, 1000000, idle cycles before auto-cancel; used only with VEND_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- nickel  input  1  one-cycle pulse, 5c inserted.
- dime  input  1  one-cycle pulse, 10c inserted.
- quarter  input  1  one-cycle pulse, 25c inserted.
- sel_valid  input  1  one-cycle selection strobe.
- sel_index  input  3  selected slot, sampled with sel_valid.
- cancel  input  1  one-cycle request to return credit.
- price_table  input  NUM_SLOTS*PRICE_W  flattened prices; slot i occupies bits [i*PRICE_W +: PRICE_W]; 0 = out of stock.
- dispense_req  output  1  product dispense request.
- dispense_index  output  3  slot to dispense, stable while dispense_req is high.
- dispense_ack  input  1  mechanism completed the dispense.
- coin_out_valid  output  1  change coin request.
- coin_out_type  output  2  01 nickel, 10 dime, 11 quarter; 00 when idle.
- coin_out_ready  input  1  hopper accepts the coin this cycle.
- credit  output  PRICE_W  current credit register.
- coin_reject  output  1  pulse: an inserted coin was refused.
- vend_done  output  1  pulse: vend transaction fully complete.
- vend_error  output  1  pulse: selection refused.
- err_code  output  2  valid with vend_error: 01 invalid or out-of-stock slot, 10 insufficient credit.

Behaviour:
- Reset (async, rst=1): state IDLE; every output is 0; the residual flag and idle counter are cleared.
- States and transitions:
  - IDLE: accepts coins, selection and cancel.
  - DISPENSE: waits for dispense_ack, then goes to CHANGE.
  - CHANGE: pays out change; returns to IDLE when credit < 5.
- Coins (IDLE only):
  - The sum of all pulses in the same cycle is added as one increment.
  - If the new credit would exceed MAX_CREDIT, the whole increment is refused and coin_reject pulses.
  - Coins arriving in DISPENSE or CHANGE are refused with coin_reject.
- Selection in IDLE:
  - Priority: cancel > selection.
  - sel_index >= NUM_SLOTS or price 0 -> vend_error, err_code=01, stay in IDLE.
  - credit < price -> vend_error, err_code=10, stay in IDLE; credit unchanged.
  - Otherwise credit <= credit - price + coins accepted this cycle; go to DISPENSE.
  - Comparison uses the registered credit, not coins arriving in the same cycle.
- DISPENSE:
  - dispense_req and dispense_index are registered and asserted on the cycle after acceptance.
  - Both are held until the cycle dispense_ack=1 is sampled; dispense_req drops on the next cycle and the state moves to CHANGE.
  - sel_valid and cancel are ignored.
- Cancel in IDLE:
  - credit > 0 -> go to CHANGE.
  - credit = 0 -> ignored.
- CHANGE:
  - Greedy coin selection: quarter if credit >= 25, else dime if >= 10, else nickel if >= 5.
  - coin_out_valid and coin_out_type are registered and held stable until coin_out_ready.
  - On valid & ready, the coin value is subtracted; the next coin is offered the following cycle at the earliest.
  - When credit < 5, any residual (price not a multiple of 5) is cleared to 0 and the state returns to IDLE.
  - vend_done pulses on exit only if CHANGE was entered from DISPENSE, including when the change is 0.
  - sel_valid and cancel are ignored.
- Reset mid-operation aborts all handshakes immediately and discards credit.

Optional Feature:
- VEND_TIMEOUT_EN defined:
  - An idle counter runs in IDLE while credit > 0.
  - It is cleared by any coin, sel_valid or cancel.
  - On reaching TIMEOUT_CYCLES it behaves exactly as cancel.
- VEND_TIMEOUT_EN undefined: no counter is built; credit is held indefinitely.

Decomposition:
- Package vend_pkg:
  - State encoding.
  - Coin type codes 01/10/11.
  - Coin value constants 5/10/25.
  - err_code values.
- Sub-module vend_change_unit:
  - Greedy coin selection and the coin valid/ready handshake.
  - Returns the decremented credit and a done indication to the top FSM.

Test Plan:
- Four nickels, then select slot 2 priced 20 -> credit 20, dispense_req with index 2; ack -> credit 0, vend_done, no coin_out_valid.
- Quarter + quarter + dime, select slot 0 priced 50 -> dispense, then one dime offered (type 10); ready held low 3 cycles keeps the coin stable; vend_done after acceptance.
- Select slot 5 priced 0 -> vend_error, err_code=01; select slot 1 priced 100 with credit 30 -> err_code=10, credit stays 30.
- Credit 40, cancel -> quarter, dime, nickel in that order, one per ready cycle; no vend_done.
- Credit 490, quarter -> coin_reject, credit stays 490; coin during DISPENSE -> coin_reject.
- VEND_TIMEOUT_EN with TIMEOUT_CYCLES=8: credit 15 and 8 idle cycles -> auto-refund of a dime then a nickel. Separately, rst asserted during CHANGE -> all outputs 0 asynchronously.
